// File: rtl/v_red_defs.sv
// Shared encodings, sideband beat type and geometry helpers for the reduction sequencer.
package v_red_defs;

   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   localparam logic [1:0] SEW_8  = 2'b00;
   localparam logic [1:0] SEW_16 = 2'b01;
   localparam logic [1:0] SEW_32 = 2'b10;
   localparam logic [1:0] SEW_64 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN
   } state_t;

   // Sideband that travels alongside each read until its data returns.
   typedef struct packed {
      logic vld;
      logic sop;
      logic eop;
      logic fill;
   } sb_t;

   // Fill bit of the op identity: all-ones for AND, zero for everything else.
   function automatic logic identity(input logic [1:0] op_sel);
      return op_sel == OP_AND;
   endfunction

   // log2 of elements per chunk; bytes_log2 is log2 of the chunk width in bytes.
   function automatic logic [3:0] epc_log2(input logic [1:0] sew, input logic [3:0] bytes_log2);
      return bytes_log2 - {2'b00, sew};
   endfunction

endpackage

// File: rtl/v_red_tail_fill.sv
// Replaces lanes at or above rem with the op identity when en is set; purely combinational.
module v_red_tail_fill
   import v_red_defs::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int REM_WIDTH  = 3
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [REM_WIDTH-1:0]  rem,
   input  logic [1:0]            sew,
   input  logic [1:0]            op_sel,
   input  logic                  en,
   output logic [DATA_WIDTH-1:0] fill_data
);

   localparam int NBYTES = DATA_WIDTH / 8;

   logic                 fill_bit;
   logic [NBYTES-1:0]    byte_mask;
   logic [REM_WIDTH-1:0] lane;

   // Mask is built per byte: a byte belongs to lane (byte >> sew).
   always_comb begin
      fill_bit  = identity(op_sel);
      byte_mask = '0;
      lane      = '0;
      fill_data = data;
      for (int b = 0; b < NBYTES; b++) begin
         lane         = REM_WIDTH'(b) >> sew;
         byte_mask[b] = en && (lane >= rem);
         if (byte_mask[b]) begin
            fill_data[b*8 +: 8] = {8{fill_bit}};
         end
      end
   end

endmodule

// File: rtl/v_red_seq.sv
// Reduction-request sequencer: one command in, one RF read per cycle, one beat per read RF_LAT cycles later.
// No output backpressure; cmd_ready is low from accept of a non-empty command until after its end beat.
module v_red_seq
   import v_red_defs::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int OPSEL_WIDTH = 2,
   parameter int SEW_WIDTH   = 2,
   parameter int VL_WIDTH    = 11,
   parameter int RF_LAT      = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_WIDTH-1:0]  cmd_vs2_addr,
   input  logic [ADDR_WIDTH-1:0]  cmd_vd_addr,
   input  logic [VL_WIDTH-1:0]    cmd_vl,
   input  logic [SEW_WIDTH-1:0]   cmd_sew,
   input  logic [OPSEL_WIDTH-1:0] cmd_opSel,
   output logic                   rf_rd_en,
   output logic [ADDR_WIDTH-1:0]  rf_rd_addr,
   input  logic [DATA_WIDTH-1:0]  rf_rd_data,
   output logic                   out_valid,
   output logic                   out_start,
   output logic                   out_end,
   output logic [DATA_WIDTH-1:0]  out_vec0,
   output logic [OPSEL_WIDTH-1:0] out_opSel,
   output logic [SEW_WIDTH-1:0]   out_sew,
   output logic [ADDR_WIDTH-1:0]  out_addr,
   output logic                   busy
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int BLOG2  = $clog2(NBYTES);
   localparam logic [BLOG2-1:0] ONES = '1;

   state_t                 state;
   logic [OPSEL_WIDTH-1:0] lat_op;
   logic [SEW_WIDTH-1:0]   lat_sew;
   logic [ADDR_WIDTH-1:0]  lat_vd;
   logic [BLOG2-1:0]       lat_rem;
   logic [VL_WIDTH-1:0]    last_k;
   logic [VL_WIDTH-1:0]    k;

   logic [3:0]             elog2;
   logic [BLOG2-1:0]       epc_m1;
   logic [VL_WIDTH:0]      vl_round;
   logic [VL_WIDTH-1:0]    cmd_nchunk;
   logic [BLOG2-1:0]       cmd_rem;

   sb_t                    issue_sb;
   sb_t                    pipe [RF_LAT];
   logic                   out_fill;
   logic [DATA_WIDTH-1:0]  filled;

   // Command geometry, evaluated on the offered fields so it can be latched at accept.
   always_comb begin
      elog2      = epc_log2(cmd_sew, 4'(BLOG2));
      epc_m1     = ~(ONES << elog2);
      vl_round   = {1'b0, cmd_vl} + (VL_WIDTH+1)'(epc_m1);
      cmd_nchunk = VL_WIDTH'(vl_round >> elog2);
      cmd_rem    = BLOG2'(cmd_vl) & epc_m1;
   end

   assign cmd_ready = rst && (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         rf_rd_en   <= 1'b0;
         rf_rd_addr <= '0;
         k          <= '0;
         last_k     <= '0;
         lat_op     <= '0;
         lat_sew    <= '0;
         lat_vd     <= '0;
         lat_rem    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  lat_op  <= cmd_opSel;
                  lat_sew <= cmd_sew;
                  lat_vd  <= cmd_vd_addr;
                  lat_rem <= cmd_rem;
                  if (cmd_vl != '0) begin
                     state      <= ST_ISSUE;
                     rf_rd_en   <= 1'b1;
                     rf_rd_addr <= cmd_vs2_addr;
                     k          <= '0;
                     last_k     <= cmd_nchunk - VL_WIDTH'(1);
                  end
               end
            end
            ST_ISSUE: begin
               rf_rd_addr <= rf_rd_addr + ADDR_WIDTH'(1);
               k          <= k + VL_WIDTH'(1);
               if (k == last_k) begin
                  rf_rd_en <= 1'b0;
                  state    <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (out_valid && out_end) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      issue_sb      = '0;
      issue_sb.vld  = rf_rd_en;
      issue_sb.sop  = rf_rd_en && (k == '0);
      issue_sb.eop  = rf_rd_en && (k == last_k);
      issue_sb.fill = rf_rd_en && (k == last_k) && (lat_rem != '0);
   end

   // Reset empties the pipe so reads in flight at reset never surface as beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RF_LAT; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= issue_sb;
         for (int i = 1; i < RF_LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign out_valid = pipe[RF_LAT-1].vld;
   assign out_start = pipe[RF_LAT-1].sop;
   assign out_end   = pipe[RF_LAT-1].eop;
   assign out_fill  = pipe[RF_LAT-1].fill;

   v_red_tail_fill #(
      .DATA_WIDTH (DATA_WIDTH),
      .REM_WIDTH  (BLOG2)
   ) u_tail_fill (
      .data      (rf_rd_data),
      .rem       (lat_rem),
      .sew       (lat_sew),
      .op_sel    (lat_op),
      .en        (out_fill),
      .fill_data (filled)
   );

   assign out_vec0  = out_valid ? filled  : '0;
   assign out_opSel = out_valid ? lat_op  : '0;
   assign out_sew   = out_valid ? lat_sew : '0;
   assign out_addr  = out_valid ? lat_vd  : '0;

endmodule

// File: tb/tb_v_red_seq.sv
// Directed bench for v_red_seq: expected reads and beats are queued at issue and checked by a negedge monitor.
module tb_v_red_seq;

   localparam int DW = 64;
   localparam int AW = 32;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_vs2_addr, cmd_vd_addr;
   logic [10:0]   cmd_vl;
   logic [1:0]    cmd_sew, cmd_opSel;
   logic          rf_rd_en;
   logic [AW-1:0] rf_rd_addr;
   logic [DW-1:0] rf_rd_data;
   logic          out_valid, out_start, out_end;
   logic [DW-1:0] out_vec0;
   logic [1:0]    out_opSel, out_sew;
   logic [AW-1:0] out_addr;
   logic          busy;

   v_red_seq #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .OPSEL_WIDTH (2),
      .SEW_WIDTH (2), .VL_WIDTH (11), .RF_LAT (LAT)
   ) dut (
      .clk (clk), .rst (rst),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
      .cmd_vs2_addr (cmd_vs2_addr), .cmd_vd_addr (cmd_vd_addr),
      .cmd_vl (cmd_vl), .cmd_sew (cmd_sew), .cmd_opSel (cmd_opSel),
      .rf_rd_en (rf_rd_en), .rf_rd_addr (rf_rd_addr), .rf_rd_data (rf_rd_data),
      .out_valid (out_valid), .out_start (out_start), .out_end (out_end),
      .out_vec0 (out_vec0), .out_opSel (out_opSel), .out_sew (out_sew),
      .out_addr (out_addr), .busy (busy)
   );

   always #5 clk = ~clk;

   // Register-file model with LAT-cycle read latency.
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [DW-1:0] rd_pipe [LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= mem.exists(rf_rd_addr) ? mem[rf_rd_addr] : 64'hDEAD_DEAD_DEAD_DEAD;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign rf_rd_data = rd_pipe[LAT-1];

   typedef struct {
      logic          s;
      logic          e;
      logic [DW-1:0] v;
      logic [1:0]    op;
      logic [1:0]    sew;
      logic [AW-1:0] addr;
   } beat_t;

   beat_t         exp_beats [$];
   logic [AW-1:0] exp_rd [$];
   beat_t         mon_b;
   logic          sb_off = 1'b0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic push_beat(input logic s, input logic e, input logic [DW-1:0] v,
                            input logic [1:0] op, input logic [1:0] sew, input logic [AW-1:0] addr);
      beat_t b;
      b.s = s; b.e = e; b.v = v; b.op = op; b.sew = sew; b.addr = addr;
      exp_beats.push_back(b);
   endtask

   // Monitor: every read and every beat must match the head of its queue.
   always @(negedge clk) begin
      if (rst && !sb_off) begin
         if (rf_rd_en) begin
            if (exp_rd.size() == 0) flag("unexpected_read");
            else check("rd_addr", 64'(rf_rd_addr), 64'(exp_rd.pop_front()));
         end
         if (out_valid) begin
            if (exp_beats.size() == 0) flag("unexpected_beat");
            else begin
               mon_b = exp_beats.pop_front();
               check("beat_start", 64'(out_start), 64'(mon_b.s));
               check("beat_end",   64'(out_end),   64'(mon_b.e));
               check("beat_vec0",  out_vec0,       mon_b.v);
               check("beat_opSel", 64'(out_opSel), 64'(mon_b.op));
               check("beat_sew",   64'(out_sew),   64'(mon_b.sew));
               check("beat_addr",  64'(out_addr),  64'(mon_b.addr));
            end
         end else begin
            check("idle_fields_zero",
                  64'(|{out_start, out_end, out_vec0, out_opSel, out_sew, out_addr}), 64'd0);
         end
      end
   end

   // Offer a command and return after the accepting edge; waits = idle cycles before acceptance.
   task automatic send(input logic [AW-1:0] vs2, input logic [AW-1:0] vd, input logic [10:0] vl,
                       input logic [1:0] sew, input logic [1:0] op, output int waits);
      waits = 0;
      @(negedge clk);
      cmd_vs2_addr = vs2; cmd_vd_addr = vd; cmd_vl = vl; cmd_sew = sew; cmd_opSel = op;
      cmd_valid = 1'b1;
      while (!cmd_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 200) flag("accept_timeout");
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_rd.size() != 0 || exp_beats.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) flag("drain_timeout");
   endtask

   initial begin
      int w;
      rst = 1'b0; cmd_valid = 1'b0;
      cmd_vs2_addr = '0; cmd_vd_addr = '0; cmd_vl = '0; cmd_sew = '0; cmd_opSel = '0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
      check("reset_outputs", 64'(|{rf_rd_en, rf_rd_addr, out_valid, out_vec0, out_addr, busy}), 64'd0);
      #2 rst = 1'b1;
      #1 check("release_cmd_ready", 64'(cmd_ready), 64'd1);

      // Full single chunk, AND, no fill; beat RF_LAT+1 cycles after the accept cycle.
      mem[32'h10] = 64'h0123_4567_89AB_CDEF;
      exp_rd.push_back(32'h10);
      push_beat(1, 1, 64'h0123_4567_89AB_CDEF, 2'b01, 2'b00, 32'h40);
      send(32'h10, 32'h40, 11'd8, 2'b00, 2'b01, w);
      @(negedge clk);
      check("t1_rd_en_cycle1", 64'(rf_rd_en), 64'd1);
      check("t1_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("t1_valid_cycle2", 64'(out_valid), 64'd1);
      wait_idle();

      // 16-bit OR, vl=5: two chunks, last keeps one lane.
      mem[32'h10] = 64'hFFFF_FFFF_FFFF_FFFF;
      mem[32'h11] = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_rd.push_back(32'h10); exp_rd.push_back(32'h11);
      push_beat(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 2'b01, 32'h44);
      push_beat(0, 1, 64'h0000_0000_0000_FFFF, 2'b10, 2'b01, 32'h44);
      send(32'h10, 32'h44, 11'd5, 2'b01, 2'b10, w);
      wait_idle();

      // 32-bit AND, vl=3: upper lane of chunk two becomes all-ones.
      mem[32'h20] = 64'hCAFE_F00D_1111_2222;
      mem[32'h21] = 64'h0000_0000_1234_5678;
      exp_rd.push_back(32'h20); exp_rd.push_back(32'h21);
      push_beat(1, 0, 64'hCAFE_F00D_1111_2222, 2'b01, 2'b10, 32'h50);
      push_beat(0, 1, 64'hFFFF_FFFF_1234_5678, 2'b01, 2'b10, 32'h50);
      send(32'h20, 32'h50, 11'd3, 2'b10, 2'b01, w);
      wait_idle();

      // vl=0 is swallowed; the next command goes in the very next cycle.
      send(32'h99, 32'h99, 11'd0, 2'b00, 2'b01, w);
      check("vl0_cmd_ready", 64'(cmd_ready), 64'd1);
      mem[32'h30] = 64'h1122_3344_5566_7788;
      exp_rd.push_back(32'h30);
      push_beat(1, 1, 64'h0022_3344_5566_7788, 2'b11, 2'b00, 32'h48);
      send(32'h30, 32'h48, 11'd7, 2'b00, 2'b11, w);
      check("vl0_next_accept_waits", 64'(w), 64'd0);
      wait_idle();

      // Back-to-back: second command held valid until ready returns after the end beat.
      mem[32'h50] = 64'hAAAA_5555_AAAA_5555;
      mem[32'h51] = 64'h0F0F_0F0F_F0F0_F0F0;
      mem[32'h70] = 64'h0000_0000_0000_0001;
      mem[32'h71] = 64'h0000_0000_0000_0002;
      exp_rd.push_back(32'h50); exp_rd.push_back(32'h51);
      exp_rd.push_back(32'h70); exp_rd.push_back(32'h71);
      push_beat(1, 0, 64'hAAAA_5555_AAAA_5555, 2'b01, 2'b00, 32'h60);
      push_beat(0, 1, 64'h0F0F_0F0F_F0F0_F0F0, 2'b01, 2'b00, 32'h60);
      push_beat(1, 0, 64'h0000_0000_0000_0001, 2'b10, 2'b11, 32'h80);
      push_beat(0, 1, 64'h0000_0000_0000_0002, 2'b10, 2'b11, 32'h80);
      send(32'h50, 32'h60, 11'd16, 2'b00, 2'b01, w);
      cmd_vs2_addr = 32'h70; cmd_vd_addr = 32'h80; cmd_vl = 11'd2; cmd_sew = 2'b11; cmd_opSel = 2'b10;
      cmd_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("b2b_cmd_ready_c%0d", i), 64'(cmd_ready), (i == 4) ? 64'd1 : 64'd0);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_idle();

      // Asynchronous reset in the middle of a long read burst.
      sb_off = 1'b1;
      send(32'h100, 32'h200, 11'd64, 2'b00, 2'b01, w);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_outputs_zero",
            64'(|{rf_rd_en, rf_rd_addr, out_valid, out_start, out_end, out_vec0, out_opSel, out_sew, out_addr, busy}),
            64'd0);
      check("arst_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check("arst_release_ready", 64'(cmd_ready), 64'd1);
      check("arst_release_busy", 64'(busy), 64'd0);
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge clk);
         check("arst_no_stray", 64'({out_valid, rf_rd_en}), 64'd0);
      end
      sb_off = 1'b0;

      // Normal operation after reset: 16-bit AND, vl=6, upper two lanes filled.
      mem[32'h200] = 64'h0000_0000_0000_0001;
      mem[32'h201] = 64'h1111_2222_3333_4444;
      exp_rd.push_back(32'h200); exp_rd.push_back(32'h201);
      push_beat(1, 0, 64'h0000_0000_0000_0001, 2'b01, 2'b01, 32'h300);
      push_beat(0, 1, 64'hFFFF_FFFF_3333_4444, 2'b01, 2'b01, 32'h300);
      send(32'h200, 32'h300, 11'd6, 2'b01, 2'b01, w);
      wait_idle();

      repeat (3) @(negedge clk);
      check("left_reads", 64'(exp_rd.size()), 64'd0);
      check("left_beats", 64'(exp_beats.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout (t=%0t)", $time);
      $fatal(1, "global timeout");
   end

endmodule
